// File: rtl/inst_rom_loader_pkg.sv
// Shared definitions for the instruction ROM loader: default NOP word,
// load FSM state encodings and the boot-header byte count.
package inst_rom_loader_pkg;

  // addi x0,x0,0
  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0013;

  // Length header and data words are both four bytes, LSB first
  localparam int HDR_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LEN  = 2'd1,
    ST_DATA = 2'd2
  } load_state_e;

endpackage

// File: rtl/rom_byte_assembler.sv
// Little-endian byte-to-word assembler. Three earlier bytes are kept in a
// shift register. The fourth byte is combined combinationally, so the word
// is usable in the same cycle as its final byte.
module rom_byte_assembler
  import inst_rom_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  cnt;
  logic [23:0] sr;

  assign word       = {byte_in, sr};
  assign word_valid = byte_valid && !clr && (cnt == 2'(HDR_BYTES - 1));

  // Byte counter wraps 3->0. New bytes enter at the top and shift down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      sr  <= '0;
    end else if (clr) begin
      cnt <= '0;
      sr  <= '0;
    end else if (byte_valid) begin
      cnt <= cnt + 2'd1;
      sr  <= {byte_in, sr[23:8]};
    end
  end

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction memory responder with an optional byte-serial boot loader.
// The ROM_BOOT_LOAD_EN macro enables the load FSM and the load ports.
// Without the macro, the load ports are ignored, the status outputs are
// tied low, and memory contents are supplied by the simulation environment.
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] NOP_WORD    = NOP_WORD_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_addr_in,
  output logic [31:0] inst_out,
  output logic        inst_valid_out,
  input  logic        load_start_in,
  input  logic [7:0]  load_byte_in,
  input  logic        load_byte_valid_in,
  output logic        hold_out,
  output logic        load_done_out,
  output logic        load_err_out
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];
  load_state_e state;
  logic        fetch_ok;

  assign fetch_ok = (inst_addr_in[31:2] < 30'(DEPTH_WORDS)) &&
                    (inst_addr_in[1:0] == 2'b00) && (state == ST_IDLE);

  // Registered fetch. Blocked, misaligned and out-of-range fetches return NOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_out       <= NOP_WORD;
      inst_valid_out <= 1'b0;
    end else if (fetch_ok) begin
      inst_out       <= mem[inst_addr_in[AW+1:2]];
      inst_valid_out <= 1'b1;
    end else begin
      inst_out       <= NOP_WORD;
      inst_valid_out <= 1'b0;
    end
  end

`ifdef ROM_BOOT_LOAD_EN
  load_state_e nstate;
  logic [AW:0] len_q, ptr_q;
  logic        err_q;
  logic        asm_clr, word_valid;
  logic [31:0] word;
  logic        wr_en, done, err_set, len_load, ptr_clr;

  // A start pulse drops any partial word. Bytes seen in IDLE never accumulate.
  assign asm_clr = load_start_in || (state == ST_IDLE);

  rom_byte_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (asm_clr),
    .byte_in    (load_byte_in),
    .byte_valid (load_byte_valid_in),
    .word       (word),
    .word_valid (word_valid)
  );

  // Load FSM next state. The start pulse wins over any byte in the same cycle.
  always_comb begin
    nstate   = state;
    wr_en    = 1'b0;
    done     = 1'b0;
    err_set  = 1'b0;
    len_load = 1'b0;
    ptr_clr  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load_start_in) begin
          nstate  = ST_LEN;
          ptr_clr = 1'b1;
        end
      end
      ST_LEN: begin
        if (load_start_in) begin
          nstate  = ST_LEN;
          ptr_clr = 1'b1;
        end else if (word_valid) begin
          if (word == 32'd0) begin
            nstate = ST_IDLE;
            done   = 1'b1;
          end else if (word > 32'(DEPTH_WORDS)) begin
            nstate  = ST_IDLE;
            err_set = 1'b1;
          end else begin
            nstate   = ST_DATA;
            len_load = 1'b1;
            ptr_clr  = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (load_start_in) begin
          nstate  = ST_LEN;
          ptr_clr = 1'b1;
        end else if (word_valid) begin
          wr_en = 1'b1;
          if (ptr_q + 1'b1 == len_q) begin
            nstate = ST_IDLE;
            done   = 1'b1;
          end
        end
      end
      default: nstate = ST_IDLE;
    endcase
  end

  // State, length, pointer and sticky error registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      len_q <= '0;
      ptr_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= nstate;
      if (len_load) len_q <= word[AW:0];
      if (ptr_clr) ptr_q <= '0;
      else if (wr_en) ptr_q <= ptr_q + 1'b1;
      if (load_start_in) err_q <= 1'b0;
      else if (err_set) err_q <= 1'b1;
    end
  end

  // Memory write port. Contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[ptr_q[AW-1:0]] <= word;
  end

  assign hold_out      = (state != ST_IDLE);
  assign load_done_out = done;
  assign load_err_out  = err_q;
`else
  logic unused_load;
  assign unused_load   = ^{load_start_in, load_byte_in, load_byte_valid_in};
  assign state         = ST_IDLE;
  assign hold_out      = 1'b0;
  assign load_done_out = 1'b0;
  assign load_err_out  = 1'b0;
`endif

endmodule

// File: tb/tb_inst_rom_loader.sv
// Self-checking bench for inst_rom_loader. It follows ROM_BOOT_LOAD_EN.
// Expected fetch results come from a word-array model of the ROM.
module tb_inst_rom_loader;
  localparam int          D   = 64;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk, rst;
  logic [31:0] inst_addr_in, inst_out;
  logic        inst_valid_out, load_start_in, load_byte_valid_in;
  logic [7:0]  load_byte_in;
  logic        hold_out, load_done_out, load_err_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] ref_mem [D];

  inst_rom_loader #(.DEPTH_WORDS(D)) dut (
    .clk                (clk),
    .rst                (rst),
    .inst_addr_in       (inst_addr_in),
    .inst_out           (inst_out),
    .inst_valid_out     (inst_valid_out),
    .load_start_in      (load_start_in),
    .load_byte_in       (load_byte_in),
    .load_byte_valid_in (load_byte_valid_in),
    .hold_out           (hold_out),
    .load_done_out      (load_done_out),
    .load_err_out       (load_err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic exp_valid(input logic [31:0] a);
    return (a / 4 < D) && (a % 4 == 0);
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return exp_valid(a) ? ref_mem[a / 4] : NOP;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 3))
      0: a = 4 * $urandom_range(0, D - 1);
      1: a = 4 * $urandom_range(0, D - 1) + $urandom_range(1, 3);
      2: a = 4 * (D + $urandom_range(0, 1000));
      default: a = $urandom;
    endcase
    return a;
  endfunction

  // All helpers start and end at a negedge
  task automatic fetch(input logic [31:0] a, output logic [31:0] d, output logic v);
    inst_addr_in = a;
    @(posedge clk); #1;
    d = inst_out;
    v = inst_valid_out;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    load_start_in = 1'b1;
    @(posedge clk); #1;
    load_start_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic put_byte(input logic [7:0] b, output logic dn, output logic hl);
    load_byte_in = b;
    load_byte_valid_in = 1'b1;
    #1;
    dn = load_done_out;
    hl = hold_out;
    @(posedge clk); #1;
    load_byte_valid_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, inout int dn_cnt, inout int hl_low);
    logic dn, hl;
    for (int b = 0; b < 4; b++) begin
      put_byte(w[8*b +: 8], dn, hl);
      if (dn) dn_cnt++;
      if (!hl) hl_low++;
    end
  endtask

  task automatic chk_fetch(input string name, input logic [31:0] a);
    logic [31:0] d;
    logic v;
    fetch(a, d, v);
    checks++;
    if (d !== exp_word(a) || v !== exp_valid(a)) begin
      errors++;
      $display("FAIL %s addr=%h got inst=%h valid=%b expected inst=%h valid=%b",
               name, a, d, v, exp_word(a), exp_valid(a));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (inst_out !== NOP || inst_valid_out !== 1'b0 || hold_out !== 1'b0 ||
        load_done_out !== 1'b0 || load_err_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got inst=%h v=%b hold=%b done=%b err=%b expected %h/0/0/0/0",
               inst_out, inst_valid_out, hold_out, load_done_out, load_err_out, NOP);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_preload();
    for (int i = 0; i < D; i++) ref_mem[i] = $urandom;
`ifdef ROM_BOOT_LOAD_EN
    begin
      int dn = 0, hl = 0;
      pulse_start();
      send_word(D, dn, hl);
      for (int i = 0; i < D; i++) send_word(ref_mem[i], dn, hl);
      checks++;
      if (dn != 1 || hl != 0 || hold_out !== 1'b0) begin
        errors++;
        $display("FAIL preload_load done_cnt=%0d hold_low=%0d hold_after=%b expected 1/0/0",
                 dn, hl, hold_out);
      end
    end
`else
    for (int i = 0; i < D; i++) dut.mem[i] = ref_mem[i];
`endif
  endtask

  task automatic test_fetch_basic();
    chk_fetch("fetch_0", 32'h0);
    chk_fetch("fetch_4", 32'h4);
  endtask

  task automatic test_bounds();
    chk_fetch("misaligned_2", 32'h2);
    chk_fetch("past_end", 32'(4 * D));
    chk_fetch("last_word", 32'(4 * D - 4));
    chk_fetch("top_addr", 32'hFFFF_FFFC);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) chk_fetch("random_fetch", rand_addr());
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    logic v;
    fetch(32'h8, d, v);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (inst_out !== NOP || inst_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got inst=%h valid=%b expected %h/0", inst_out, inst_valid_out, NOP);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

`ifdef ROM_BOOT_LOAD_EN
  task automatic test_load_basic();
    int dn = 0, hl = 0;
    pulse_start();
    checks++;
    if (hold_out !== 1'b1) begin
      errors++;
      $display("FAIL hold_rise got %b expected 1", hold_out);
    end
    send_word(32'd2, dn, hl);
    send_word(32'h0010_0513, dn, hl);
    send_word(32'h0020_0593, dn, hl);
    checks++;
    if (dn != 1 || hl != 0 || hold_out !== 1'b0) begin
      errors++;
      $display("FAIL load_basic done_cnt=%0d hold_low=%0d hold_after=%b expected 1/0/0", dn, hl, hold_out);
    end
    ref_mem[0] = 32'h0010_0513;
    ref_mem[1] = 32'h0020_0593;
    chk_fetch("load_w0", 32'h0);
    chk_fetch("load_w1", 32'h4);
  endtask

  task automatic test_len_err();
    int dn = 0, hl = 0;
    pulse_start();
    send_word(32'(D + 1), dn, hl);
    repeat (3) @(negedge clk);
    checks++;
    if (load_err_out !== 1'b1 || hold_out !== 1'b0 || dn != 0) begin
      errors++;
      $display("FAIL len_err err=%b hold=%b done_cnt=%0d expected 1/0/0", load_err_out, hold_out, dn);
    end
    for (int i = 0; i < 3; i++) chk_fetch("err_mem_kept", 4 * $urandom_range(0, D - 1));
    pulse_start();
    checks++;
    if (load_err_out !== 1'b0 || hold_out !== 1'b1) begin
      errors++;
      $display("FAIL err_clear err=%b hold=%b expected 0/1", load_err_out, hold_out);
    end
    dn = 0;
    hl = 0;
    send_word(32'd0, dn, hl);
    checks++;
    if (dn != 1 || hl != 0 || hold_out !== 1'b0) begin
      errors++;
      $display("FAIL zero_len done_cnt=%0d hold_low=%0d hold_after=%b expected 1/0/0", dn, hl, hold_out);
    end
  endtask

  task automatic test_restart();
    int dn = 0, hl = 0;
    logic d, h;
    logic [31:0] wa, wb, wc;
    wa = $urandom;
    wb = $urandom;
    wc = $urandom;
    pulse_start();
    send_word(32'd2, dn, hl);
    send_word(wa, dn, hl);
    put_byte(wb[7:0], d, h);
    put_byte(wb[15:8], d, h);
    load_start_in = 1'b1;
    load_byte_valid_in = 1'b1;
    load_byte_in = 8'h05;
    @(posedge clk); #1;
    load_start_in = 1'b0;
    load_byte_valid_in = 1'b0;
    @(negedge clk);
    ref_mem[0] = wa;
    checks++;
    if (hold_out !== 1'b1 || dn != 0) begin
      errors++;
      $display("FAIL restart_hold hold=%b done_cnt=%0d expected 1/0", hold_out, dn);
    end
    send_word(32'd1, dn, hl);
    send_word(wc, dn, hl);
    ref_mem[0] = wc;
    checks++;
    if (dn != 1 || hl != 0 || hold_out !== 1'b0 || load_err_out !== 1'b0) begin
      errors++;
      $display("FAIL restart_load done_cnt=%0d hold_low=%0d hold=%b err=%b expected 1/0/0/0",
               dn, hl, hold_out, load_err_out);
    end
    chk_fetch("restart_w0", 32'h0);
    chk_fetch("restart_w1", 32'h4);
  endtask

  task automatic test_reset_mid_data();
    int dn = 0, hl = 0;
    logic d, h;
    logic [31:0] we;
    we = $urandom;
    pulse_start();
    send_word(32'd3, dn, hl);
    send_word(we, dn, hl);
    put_byte(8'hAA, d, h);
    ref_mem[0] = we;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (hold_out !== 1'b0 || inst_out !== NOP) begin
      errors++;
      $display("FAIL reset_mid_data hold=%b inst=%h expected 0/%h", hold_out, inst_out, NOP);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (hold_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle hold=%b expected 0", hold_out);
    end
    chk_fetch("partial_w0", 32'h0);
    chk_fetch("partial_w1", 32'h4);
  endtask

  task automatic test_idle_bytes();
    int dn = 0, hl = 0;
    send_word($urandom, dn, hl);
    send_word(32'd1, dn, hl);
    checks++;
    if (dn != 0 || hl != 8) begin
      errors++;
      $display("FAIL idle_bytes done_cnt=%0d hold_low=%0d expected 0/8", dn, hl);
    end
    chk_fetch("idle_mem", 32'h0);
  endtask
`else
  task automatic test_load_ignored();
    int dn = 0, hl = 0;
    pulse_start();
    send_word(32'd1, dn, hl);
    send_word(32'hDEAD_BEEF, dn, hl);
    checks++;
    if (dn != 0 || hl != 8 || load_err_out !== 1'b0) begin
      errors++;
      $display("FAIL load_ignored done_cnt=%0d hold_low=%0d err=%b expected 0/8/0", dn, hl, load_err_out);
    end
    chk_fetch("ignored_mem", 32'h0);
  endtask
`endif

  initial begin
    rst = 1'b1;
    inst_addr_in = '0;
    load_start_in = 1'b0;
    load_byte_in = '0;
    load_byte_valid_in = 1'b0;
    test_reset();
    test_preload();
    test_fetch_basic();
    test_bounds();
    test_back_to_back();
    test_async_reset();
`ifdef ROM_BOOT_LOAD_EN
    test_load_basic();
    test_len_err();
    test_restart();
    test_reset_mid_data();
    test_idle_bytes();
`else
    test_load_ignored();
`endif
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
